qsys_avalon_st_packet_arbiter: RTL
==================================

Name: qsys_avalon_st_packet_arbiter

Overview:
Two-input Avalon-ST packet arbiter. It shares one 32-bit packet sink between two packet sources. Arbitration is round-robin at packet boundaries, and a grant is held from the startofpacket beat through the endofpacket beat. Each source's 6-bit error vector is collapsed to the sink's 1-bit error, a per-beat channel tag identifies the source, and accepted packets are counted per source for software status.

Parameters:
DATA_W, 32, data width in bits (EMPTY_W = log2(DATA_W/8)).
ERR_W, 6, input error vector width.
CNT_W, 16, width of the per-source packet counters.

Ports:
clk  in  1  single clock, all logic rising-edge.
reset_n  in  1  synchronous, active-low reset.
in0_ready  out  1  sink ready to source 0.
in0_valid  in  1  source 0 beat valid.
in0_data  in  DATA_W  source 0 data.
in0_error  in  ERR_W  source 0 error vector.
in0_startofpacket  in  1  source 0 first beat.
in0_endofpacket  in  1  source 0 last beat.
in0_empty  in  EMPTY_W  source 0 empty symbols on last beat.
in1_ready, in1_valid, in1_data, in1_error, in1_startofpacket, in1_endofpacket, in1_empty: same as source 0.
out_ready  in  1  downstream ready.
out_valid  out  1  beat valid.
out_data  out  DATA_W  muxed data.
out_error  out  1  OR of the granted source's in_error, plus the protocol error (see below).
out_startofpacket, out_endofpacket, out_empty: muxed from the granted source.
out_channel  out  1  index of the granted source.
pkt_count0, pkt_count1  out  CNT_W  packets completed per source, wrapping.
busy  out  1  high while a grant is held.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous, active-low.
- Reset values: state=IDLE, rr_last=1 (so source 0 wins the first tie), pkt_count0/1=0, busy=0, out_valid=0, in0_ready=in1_ready=0.
- State IDLE:
  - req0=in0_valid, req1=in1_valid.
  - Exactly one request: grant that source.
  - Both request: grant the source not equal to rr_last.
  - Registered transition to GRANT0 or GRANT1. No beat is accepted in IDLE.
  - Latency: one cycle from first valid to out_valid.
- State GRANTn:
  - Datapath is combinational: out_* = inn_*; out_valid = inn_valid; inn_ready = out_ready; the other source's ready = 0; out_channel = n; busy = 1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - Data, sop, eop, empty and error are not altered.
  - Valid may drop mid-packet; the grant is held regardless (no timeout, no truncation).
- Packet end:
  - A transfer with endofpacket=1 → next state IDLE, rr_last=n, pkt_count n += 1 (wraps at 2^CNT_W−1 → 0).
  - A one-cycle bubble follows, then re-arbitration. With both sources saturated, output alternates packets 0,1,0,1.
- Single-beat packet (sop and eop on the same transfer): counted and released exactly as above.
- Protocol error:
  - The first transfer after a grant lacks startofpacket → out_error=1 on that beat only; the beat is still forwarded.
  - A startofpacket on a non-first beat of a granted packet → out_error=1 on that beat; the packet continues.
  - Tracking uses a first_beat flag, set on entry to GRANTn and cleared on the first transfer.
- Reset mid-packet: return to IDLE immediately and zero the counters. Downstream sees the packet truncated without eop; this is acceptable and documented.
- out_* in IDLE: out_valid=0, out_channel=rr_last, other out_* fields are don't-care but driven from source 0.

Decomposition:
- Shared package qsys_avalon_st_pkg: state encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10), EMPTY_W function, default widths.
- One natural sub-module, qsys_avalon_st_rr_arb2: the 2-requester round-robin picker with its rr_last register and update-on-release input.
- The top level holds the FSM, the mux, the error logic and the counters.

Test Plan:
1. Single source: in0 sends a 3-beat packet (sop beat 1, eop beat 3, empty=2), out_ready=1 → out_valid rises one cycle after in0_valid; 3 beats out, out_channel=0, out_empty=2 on beat 3, pkt_count0=1, busy drops the cycle after eop.
2. Contention: both sources continuously send 2-beat packets for 6 packets → output order 0,1,0,1,0,1; one idle cycle between packets; pkt_count0=pkt_count1=3; in1_ready=0 throughout source 0's packets.
3. Backpressure: out_ready toggles 1,0,1,0 during a 4-beat in1 packet → in1_ready mirrors out_ready; exactly 4 transfers; no duplicated or lost beats; the grant is held through stalls.
4. Error mapping: in0_error=6'b000100 on beat 2 only → out_error=1 on beat 2 only. in1 starts a packet without sop → out_error=1 on its first beat.
5. Reset mid-packet: reset_n=0 for one cycle during beat 2 of a 5-beat in0 packet → next cycle state=IDLE, busy=0, counters=0; a fresh in1 packet then wins (rr_last=1 tie rule doesn't apply; single request).
6. Counter wrap: force pkt_count0 to 16'hFFFF, complete one in0 packet → pkt_count0=0, pkt_count1 unchanged.

Source files
------------

// File: rtl/qsys_avalon_st_pkg.sv
// qsys_avalon_st_pkg: shared state encoding, default widths and empty-width helper
package qsys_avalon_st_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ERR_W_DEF = 6;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT0 = 2'b01, GRANT1 = 2'b10} state_t;
  function automatic int empty_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction
endpackage

// File: rtl/qsys_avalon_st_rr_arb2.sv
// qsys_avalon_st_rr_arb2: two-requester round-robin picker, last winner updated on packet release
module qsys_avalon_st_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       release_en,
  input  logic       release_idx,
  output logic       gnt,
  output logic       rr_last
);
  assign gnt = (&req) ? ~rr_last : req[1];
  always_ff @(posedge clk)
    if (!reset_n) rr_last <= 1'b1;
    else if (release_en) rr_last <= release_idx;
endmodule

// File: rtl/qsys_avalon_st_packet_arbiter.sv
// qsys_avalon_st_packet_arbiter: two-source Avalon-ST packet arbiter, grant held sop..eop, round-robin between packets
module qsys_avalon_st_packet_arbiter
  import qsys_avalon_st_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ERR_W = ERR_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int EMPTY_W = empty_w(DATA_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               in0_ready,
  input  logic               in0_valid,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [ERR_W-1:0]   in0_error,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in1_ready,
  input  logic               in1_valid,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [ERR_W-1:0]   in1_error,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_channel,
  output logic [CNT_W-1:0]   pkt_count0,
  output logic [CNT_W-1:0]   pkt_count1,
  output logic               busy
);
  state_t state;
  logic first_beat, granted, sel, xfer, done, gnt, rr_last;
  assign granted = (state != IDLE);
  assign sel = (state == GRANT1);
  assign busy = granted;
  assign out_valid = granted & (sel ? in1_valid : in0_valid);
  assign in0_ready = (state == GRANT0) & out_ready;
  assign in1_ready = sel & out_ready;
  assign out_data = sel ? in1_data : in0_data;
  assign out_startofpacket = sel ? in1_startofpacket : in0_startofpacket;
  assign out_endofpacket = sel ? in1_endofpacket : in0_endofpacket;
  assign out_empty = sel ? in1_empty : in0_empty;
  assign out_channel = granted ? sel : rr_last;
  // a first beat without sop, or a later beat with sop, is flagged but still forwarded
  assign out_error = (sel ? |in1_error : |in0_error)
                   | (out_valid & (first_beat ? ~out_startofpacket : out_startofpacket));
  assign xfer = out_valid & out_ready;
  assign done = xfer & out_endofpacket;
  qsys_avalon_st_rr_arb2 u_arb (
    .clk(clk),
    .reset_n(reset_n),
    .req(granted ? 2'b00 : {in1_valid, in0_valid}),
    .release_en(done),
    .release_idx(sel),
    .gnt(gnt),
    .rr_last(rr_last)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      first_beat <= 1'b0;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else if (!granted) begin
      if (in0_valid | in1_valid) begin
        state <= gnt ? GRANT1 : GRANT0;
        first_beat <= 1'b1;
      end
    end else if (xfer) begin
      first_beat <= 1'b0;
      if (out_endofpacket) begin
        state <= IDLE;
        if (sel) pkt_count1 <= pkt_count1 + CNT_W'(1);
        else pkt_count0 <= pkt_count0 + CNT_W'(1);
      end
    end
endmodule
